// File: rtl/inst_fetch_queue.sv
// Instruction fetch unit: issues sequential fetches under a credit limit and
// buffers returned words with their pcs in a small FIFO for decode.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MAX_OUT  = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop_cnt;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];

  logic          accept;
  logic          enq;
  logic          deq;
  logic          drop;
  logic [31:0]   in_use;
  logic [OW-1:0] out_after_resp;

  // Queued plus in-flight words may never exceed DEPTH, so a returning
  // response always has a free slot.
  assign in_use         = 32'(count) + 32'(outstanding);
  assign imem_req_valid = rstn && !redirect_valid &&
                          (outstanding < OW'(MAX_OUT)) && (in_use < 32'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;

  assign drop           = imem_resp_valid && (drop_cnt != '0);
  assign enq            = rstn && !redirect_valid && imem_resp_valid && (drop_cnt == '0);
  assign out_valid      = (count != '0);
  assign deq            = rstn && !redirect_valid && out_valid && out_ready;
  assign out_inst       = inst_mem[head];
  assign out_pc         = pc_mem[head];

  assign out_after_resp = outstanding - OW'(imem_resp_valid);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path and must be discarded.
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= out_after_resp;
      drop_cnt    <= out_after_resp;
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      outstanding <= out_after_resp + OW'(accept);
      if (drop) drop_cnt <= drop_cnt - OW'(1);
      if (enq) begin
        tail    <= tail + AW'(1);
        resp_pc <= resp_pc + 32'd4;
      end
      if (deq) head <= head + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[tail] <= imem_resp_data;
      pc_mem[tail]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: in-order memory model with configurable latency,
// directed scenarios and a randomized run checked against the expected pc stream.
module tb_inst_fetch_queue;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;

  inst_fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rstn(rstn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int mem_lat = 1;
  bit mem_rand = 0;

  logic [31:0] mq[$];
  int          mq_rdy[$];
  logic [31:0] acc_log[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  int          got_cyc[$];

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // One clock cycle: observe handshakes at the falling edge, then after the
  // rising edge present the next in-order memory response if one is due.
  task automatic step();
    @(negedge clk);
    if (rstn && !redirect_valid && out_valid && out_ready) begin
      got_pc.push_back(out_pc);
      got_inst.push_back(out_inst);
      got_cyc.push_back(cyc);
    end
    if (imem_req_valid && imem_req_ready) begin
      acc_log.push_back(imem_req_addr);
      mq.push_back(imem_req_addr);
      mq_rdy.push_back(cyc + (mem_rand ? int'($urandom_range(1, 3)) : mem_lat));
    end
    @(posedge clk);
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (mq.size() > 0 && mq_rdy[0] <= cyc && (!mem_rand || $urandom_range(0, 1) == 1)) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memw(mq[0]);
      void'(mq.pop_front());
      void'(mq_rdy.pop_front());
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    mem_rand = 0;
    step();
    step();
    for (int i = 0; i < 30 && (mq.size() > 0 || imem_resp_valid); i++) step();
    if (mq.size() > 0 || imem_resp_valid) begin
      n_total++;
      $display("FAIL drain_timeout: pending=%0d", mq.size());
    end
    mem_lat = 1;
    rstn = 1'b1;
    got_pc.delete();
    got_inst.delete();
    got_cyc.delete();
    acc_log.delete();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    step();
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_total++; if (imem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h want 0", imem_req_addr); else n_pass++;
    do_reset();
    #1;
    n_total++; if (imem_req_valid !== 1'b1) $display("FAIL post_rst_req_valid: got %b want 1", imem_req_valid); else n_pass++;
    n_total++; if (imem_req_addr !== 32'h0) $display("FAIL post_rst_req_addr: got %h want 0", imem_req_addr); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_stream();
    int c0;
    do_reset();
    c0 = cyc;
    for (int i = 0; i < 20; i++) step();
    n_total++; if (got_pc.size() != 18) $display("FAIL stream_count: got %0d want 18", got_pc.size()); else n_pass++;
    for (int i = 0; i < 18 && i < got_pc.size(); i++) begin
      n_total++;
      if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== memw(32'(4 * i)) || got_cyc[i] != c0 + 2 + i)
        $display("FAIL stream_%0d: pc %h inst %h cyc %0d want pc %h inst %h cyc %0d",
                 i, got_pc[i], got_inst[i], got_cyc[i], 4 * i, memw(32'(4 * i)), c0 + 2 + i);
      else n_pass++;
    end
  endtask

  task automatic test_fill();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    n_total++; if (got_pc.size() != 0) $display("FAIL fill_pops: got %0d want 0", got_pc.size()); else n_pass++;
    n_total++; if (acc_log.size() != 4) $display("FAIL fill_reqs: got %0d want 4", acc_log.size()); else n_pass++;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL fill_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    n_total++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL fill_head: valid %b pc %h want 1 0", out_valid, out_pc); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    n_total++; if (got_pc.size() != 4) $display("FAIL drain_count: got %0d want 4", got_pc.size()); else n_pass++;
    for (int i = 0; i < 4 && i < got_pc.size(); i++) begin
      n_total++;
      if (got_pc[i] !== 32'(4 * i) || got_inst[i] !== memw(32'(4 * i)))
        $display("FAIL drain_%0d: pc %h inst %h want pc %h", i, got_pc[i], got_inst[i], 4 * i);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 3; i++) step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_total++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC)
        $display("FAIL stall_%0d: valid %b addr %h want 1 0000000c", i, imem_req_valid, imem_req_addr);
      else n_pass++;
      if (i < 3) step();
    end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 40 && got_pc.size() < 8; i++) step();
    n_total++; if (got_pc.size() < 8) $display("FAIL stall_resume_count: got %0d want 8", got_pc.size()); else n_pass++;
    for (int i = 0; i < 8 && i < got_pc.size(); i++) begin
      n_total++;
      if (got_pc[i] !== 32'(4 * i)) $display("FAIL stall_resume_%0d: pc %h want %h", i, got_pc[i], 4 * i);
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_lat = 3;
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    n_total++;
    if (acc_log.size() != 2 || acc_log[0] !== 32'h10 || acc_log[1] !== 32'h14 || imem_resp_valid !== 1'b0)
      $display("FAIL redir_inflight: reqs %0d resp %b want 2 requests 10,14 none returned", acc_log.size(), imem_resp_valid);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    n_total++; if (got_pc.size() < 2) $display("FAIL redir_count: got %0d want >=2", got_pc.size()); else n_pass++;
    if (got_pc.size() >= 2) begin
      n_total++; if (got_pc[0] !== 32'h100) $display("FAIL redir_pc: got %h want 00000100", got_pc[0]); else n_pass++;
      n_total++; if (got_inst[0] !== memw(32'h100)) $display("FAIL redir_inst: got %h want %h", got_inst[0], memw(32'h100)); else n_pass++;
      n_total++; if (got_pc[1] !== 32'h104) $display("FAIL redir_pc1: got %h want 00000104", got_pc[1]); else n_pass++;
    end
  endtask

  task automatic test_redirect_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_total++;
    if (imem_resp_valid !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL rf_setup: resp %b out_valid %b want 1 1", imem_resp_valid, out_valid);
    else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    out_ready = 1'b1;
    #1;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL rf_req_valid: got %b want 0", imem_req_valid); else n_pass++;
    step();
    redirect_valid = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rf_empty: out_valid %b want 0", out_valid); else n_pass++;
    for (int i = 0; i < 10; i++) step();
    n_total++;
    if (got_pc.size() == 0 || got_pc[0] !== 32'h200 || got_inst[0] !== memw(32'h200))
      $display("FAIL rf_first: n %0d pc %h want 00000200", got_pc.size(), (got_pc.size() > 0) ? got_pc[0] : 32'hx);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rstn = 1'b0;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (imem_req_addr !== 32'h0) $display("FAIL midrst_addr: got %h want 0", imem_req_addr); else n_pass++;
    n_total++; if (imem_req_valid !== 1'b0) $display("FAIL midrst_req_valid: got %b want 0", imem_req_valid); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] pend_addr;
    bit          pend;
    int          n_pops;
    int          bad;
    do_reset();
    mem_rand = 1;
    exp_pc = 32'h0;
    pend = 0;
    pend_addr = 32'h0;
    n_pops = 0;
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      redirect_valid = ($urandom_range(0, 29) == 0);
      if (redirect_valid) redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      imem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      #1;
      if (pend && !redirect_valid) begin
        n_total++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== pend_addr)
          $display("FAIL rnd_hold c%0d: valid %b addr %h want 1 %h", c, imem_req_valid, imem_req_addr, pend_addr);
        else n_pass++;
      end
      pend = imem_req_valid && !imem_req_ready;
      pend_addr = imem_req_addr;
      step();
      while (got_pc.size() > 0) begin
        pc = got_pc.pop_front();
        inst = got_inst.pop_front();
        void'(got_cyc.pop_front());
        n_pops++;
        n_total++;
        if (pc !== exp_pc || inst !== memw(exp_pc)) begin
          if (bad < 10) $display("FAIL rnd_pop c%0d: pc %h inst %h want pc %h inst %h", c, pc, inst, exp_pc, memw(exp_pc));
          bad++;
        end else n_pass++;
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_valid) exp_pc = redirect_pc;
    end
    redirect_valid = 1'b0;
    mem_rand = 0;
    n_total++; if (n_pops < 300) $display("FAIL rnd_progress: pops %0d want >=300", n_pops); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    out_ready = 1'b1;
    test_reset();
    test_stream();
    test_fill();
    test_stall();
    test_redirect();
    test_redirect_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
